// File: rtl/ucdp_fifo_reader.sv
// ucdp_fifo_reader: pulls a burst of len_i words from an upstream FIFO and
// streams them out through a 2-entry valid/ready skid buffer.
// Optional feature: define UCDP_FIFO_READER_ABORT_EN to add abort_i, which
// stops further FIFO reads mid-burst while still draining buffered words.
module ucdp_fifo_reader #(
  parameter int width_p     = 8,
  parameter int len_width_p = 4
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_i,
  input  logic                   start_i,
  input  logic [len_width_p-1:0] len_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic [width_p-1:0]     fifo_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
`ifdef UCDP_FIFO_READER_ABORT_EN
  output logic [width_p-1:0]     out_data_o,
  input  logic                   abort_i
`else
  output logic [width_p-1:0]     out_data_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [len_width_p-1:0] LenOne  = {{(len_width_p-1){1'b0}}, 1'b1};
  localparam logic [len_width_p-1:0] LenZero = '0;

  state_e                 state_q, state_d;
  logic [len_width_p-1:0] rem_q, rem_d;
  logic [1:0]             occ_q, occ_d;
  logic [width_p-1:0]     buf0_q, buf0_d;
  logic [width_p-1:0]     buf1_q, buf1_d;

  logic abort_w;
  logic load_w;
  logic push_w;
  logic pop_w;

`ifdef UCDP_FIFO_READER_ABORT_EN
  assign abort_w = abort_i & (state_q == READ);
`else
  assign abort_w = 1'b0;
`endif

  // A burst is accepted only from IDLE and only with a non-zero length.
  assign load_w = (state_q == IDLE) & start_i & (len_i != LenZero);
  // Read only while room remains in the buffer; the abort cycle itself
  // issues no read so nothing beyond the abort point is fetched.
  assign push_w = (state_q == READ) & (rem_q != LenZero) & ~fifo_empty_i &
                  (occ_q < 2'd2) & ~abort_w;
  assign pop_w  = (occ_q != 2'd0) & out_ready_i;

  // State register.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; READ and FLUSH look at the next counter values so the
  // exit happens in the same cycle as the final read or final pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_w) state_d = READ;
      READ:    if (rem_d == LenZero) state_d = FLUSH;
      FLUSH:   if (occ_d == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state and buffer occupancy.
  always_comb begin
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    fifo_rd_en_o = push_w;
    out_valid_o  = (occ_q != 2'd0);
    out_data_o   = buf0_q;
  end

  // Remaining-word counter and buffer occupancy next-state.
  always_comb begin
    rem_d = rem_q;
    if (load_w) begin
      rem_d = len_i;
    end else if (abort_w) begin
      rem_d = LenZero;
    end else if (push_w) begin
      rem_d = rem_q - LenOne;
    end

    occ_d = occ_q;
    case ({push_w, pop_w})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // In-order buffer: buf0 is always the oldest word (the output head).
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push_w, pop_w})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data_i;
        else               buf1_d = fifo_data_i;
      end
      2'b01: begin
        buf0_d = buf1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_i;
        end
      end
      default: begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
      end
    endcase
  end

  // Counter and buffer registers; reset clears data too so out_data_o reads 0.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      rem_q  <= LenZero;
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      rem_q  <= rem_d;
      occ_q  <= occ_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

endmodule

// File: tb/tb_ucdp_fifo_reader.sv
// Bench for ucdp_fifo_reader: behavioural upstream FIFO plus a scoreboard of
// expected output words filled when each burst is launched.
module tb_ucdp_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       busy, done;
  logic       empty;
  logic       rd_en;
  logic [7:0] fdata;
  logic       valid;
  logic       ready;
  logic [7:0] odata;
  logic       starve;
`ifdef UCDP_FIFO_READER_ABORT_EN
  logic       abort;
`endif

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int rd_cnt, hs_cnt, done_cnt, first_rd, first_hs, last_hs, gap_err, done_cyc;

  always #5 clk = ~clk;

  ucdp_fifo_reader #(.width_p(8), .len_width_p(4)) dut (
    .main_clk_i   (clk),
    .main_rst_i   (rst),
    .start_i      (start),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_empty_i (empty),
    .fifo_rd_en_o (rd_en),
    .fifo_data_i  (fdata),
    .out_valid_o  (valid),
    .out_ready_i  (ready),
`ifdef UCDP_FIFO_READER_ABORT_EN
    .out_data_o   (odata),
    .abort_i      (abort)
`else
    .out_data_o   (odata)
`endif
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, req);
  endtask

  task automatic upd_fifo();
    empty = starve || (fq.size() == 0);
    fdata = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  task automatic clr_stats();
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0; gap_err = 0;
    first_rd = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  // One clock: sample at the falling edge, then advance the FIFO model just
  // after the rising edge so the DUT saw the old head word.
  task automatic tick();
    logic       rd;
    logic [7:0] e;
    @(negedge clk);
    rd = rd_en;
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      chk_eq("no_underflow", empty, 1'b0);
    end
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_extra_word", odata, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk_eq("sb_data", odata, e);
      end
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      else if (cyc != last_hs + 1) gap_err++;
      last_hs = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    upd_fifo();
  endtask

  task automatic start_burst(input int n, input int nexp);
    len   = n[3:0];
    start = 1'b1;
    for (int i = 0; i < nexp && i < fq.size(); i++) exp_q.push_back(fq[i]);
    tick();
    start = 1'b0;
  endtask

  task automatic run_done(input string tag, input int maxc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      tick();
      k++;
    end
    chk_eq(tag, done_cnt, 1);
  endtask

  task automatic load_fifo(input logic [7:0] base, input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    upd_fifo();
  endtask

  initial begin
    int bad;
    logic [7:0] held;
    rst = 1'b1; start = 1'b0; len = 4'd0; ready = 1'b0; starve = 1'b0;
`ifdef UCDP_FIFO_READER_ABORT_EN
    abort = 1'b0;
`endif
    upd_fifo();
    clr_stats();

    // reset state
    @(negedge clk);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_rd_en", rd_en, 1'b0);
    chk_eq("rst_valid", valid, 1'b0);
    chk_eq("rst_data", odata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic 3-word burst at full rate
    load_fifo(8'h11, 3);
    ready = 1'b1;
    clr_stats();
    start_burst(3, 3);
    run_done("b3_done", 20);
    chk_eq("b3_rd_cnt", rd_cnt, 3);
    chk_eq("b3_hs_cnt", hs_cnt, 3);
    chk_eq("b3_first_lat", first_hs, first_rd + 1);
    chk_eq("b3_gap", gap_err, 0);
    chk_eq("b3_done_lat", done_cyc, last_hs + 1);
    chk_eq("b3_sb_empty", exp_q.size(), 0);
    chk_eq("b3_idle", busy, 1'b0);

    // backpressure: only two reads while the sink stalls
    load_fifo(8'hA1, 4);
    ready = 1'b0;
    clr_stats();
    start_burst(4, 4);
    repeat (6) tick();
    chk_eq("bp_rd_cnt", rd_cnt, 2);
    chk_eq("bp_valid", valid, 1'b1);
    held = odata;
    chk_eq("bp_head", held, 8'hA1);
    repeat (3) tick();
    chk_eq("bp_stable", odata, held);
    chk_eq("bp_rd_still", rd_cnt, 2);
    ready = 1'b1;
    run_done("bp_done", 20);
    chk_eq("bp_rd_total", rd_cnt, 4);
    chk_eq("bp_hs", hs_cnt, 4);
    chk_eq("bp_sb_empty", exp_q.size(), 0);

    // upstream starvation
    load_fifo(8'hB1, 2);
    starve = 1'b1;
    upd_fifo();
    clr_stats();
    start_burst(2, 2);
    bad = 0;
    repeat (5) begin
      tick();
      if (rd_cnt != 0 || !busy) bad++;
    end
    chk_eq("starve_stall", bad, 0);
    starve = 1'b0;
    upd_fifo();
    run_done("starve_done", 20);
    chk_eq("starve_hs", hs_cnt, 2);
    chk_eq("starve_sb_empty", exp_q.size(), 0);

    // ignored starts: len 0 in IDLE, and a restart during READ
    load_fifo(8'hC1, 5);
    clr_stats();
    len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk_eq("len0_busy", busy, 1'b0);
    chk_eq("len0_rd", rd_cnt, 0);
    start_burst(3, 3);
    tick();
    len = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    run_done("restart_done", 20);
    chk_eq("restart_rd", rd_cnt, 3);
    chk_eq("restart_left", fq.size(), 2);
    chk_eq("restart_sb_empty", exp_q.size(), 0);
    tick();
    chk_eq("restart_idle", busy, 1'b0);

    // reset mid-burst with two words buffered
    load_fifo(8'hD1, 4);
    ready = 1'b0;
    clr_stats();
    start_burst(4, 4);
    repeat (3) tick();
    chk_eq("mid_valid", valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_busy", busy, 1'b0);
    chk_eq("mid_rst_done", done, 1'b0);
    chk_eq("mid_rst_rd", rd_en, 1'b0);
    chk_eq("mid_rst_valid", valid, 1'b0);
    chk_eq("mid_rst_data", odata, 8'h00);
    repeat (3) tick();
    chk_eq("mid_rst_no_done", done_cnt, 0);
    rst = 1'b0;
    exp_q.delete();
    load_fifo(8'hE1, 2);
    ready = 1'b1;
    clr_stats();
    start_burst(2, 2);
    run_done("post_rst_done", 20);
    chk_eq("post_rst_hs", hs_cnt, 2);
    chk_eq("post_rst_sb_empty", exp_q.size(), 0);

`ifdef UCDP_FIFO_READER_ABORT_EN
    // abort after three reads of an 8-word burst
    begin
      int k;
      load_fifo(8'hF0, 8);
      ready = 1'b1;
      clr_stats();
      start_burst(8, 3);
      k = 0;
      while (rd_cnt < 3 && k < 20) begin
        tick();
        k++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      run_done("abort_done", 20);
      chk_eq("abort_rd", rd_cnt, 3);
      chk_eq("abort_hs", hs_cnt, 3);
      chk_eq("abort_left", fq.size(), 5);
      chk_eq("abort_sb_empty", exp_q.size(), 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
